// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative MUL/DIV/MOD unit and the control unit that issues to it.
package muldiv_iter_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int DEST_W_DEF = 6;

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_MOD = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  function automatic logic is_valid_op(input logic [3:0] op_code);
    return (op_code == OP_MUL) || (op_code == OP_DIV) || (op_code == OP_MOD);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply step or restoring-divide step, chosen by op.
module muldiv_step
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]         op,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH:0]     rem_in,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [WIDTH:0]     rem_out
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // Next accumulator / remainder for a single iteration.
  always_comb begin
    w_sum       = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    w_shift_rem = {rem_in[WIDTH-1:0], acc_in[WIDTH-1]};
    w_diff      = w_shift_rem - {1'b0, divisor};
    // rem_in[WIDTH] set means the shifted value already exceeds any divisor;
    // the modular difference is still exact because remainder < divisor.
    w_ge        = rem_in[WIDTH] | (w_shift_rem >= {1'b0, divisor});
    acc_out     = acc_in;
    rem_out     = rem_in;
    case (op)
      OP_MUL: begin
        if (acc_in[0]) begin
          acc_out = {w_sum, acc_in[WIDTH-1:1]};
        end else begin
          acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
        end
        rem_out = rem_in;
      end
      OP_DIV, OP_MOD: begin
        if (w_ge) begin
          rem_out = w_diff;
          acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b1};
        end else begin
          rem_out = w_shift_rem;
          acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_out = acc_in;
        rem_out = rem_in;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MUL/DIV/MOD execute unit: one result bit per cycle, done WIDTH+1 cycles after accept.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [DEST_W-1:0] dest_out,
  output logic              dz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [DEST_W-1:0]  r_dest;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic [DEST_W-1:0]  r_dest_out;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_rem_nxt;
  logic               w_accept;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (r_op),
    .acc_in  (r_acc),
    .rem_in  (r_rem),
    .mcand   (r_a),
    .divisor (r_b),
    .acc_out (w_acc_nxt),
    .rem_out (w_rem_nxt)
  );

  // Accept qualification and selection of the value presented on FIN entry.
  always_comb begin
    w_accept   = 1'b0;
    w_div_zero = (r_op != OP_MUL) && (r_b == {WIDTH{1'b0}});
    w_res_lo   = {WIDTH{1'b0}};
    w_res_hi   = {WIDTH{1'b0}};
    if (((r_state == ST_IDLE) || (r_state == ST_FIN)) && start && !flush && is_valid_op(op)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
    case (r_op)
      OP_MUL: begin
        w_res_lo = w_acc_nxt[WIDTH-1:0];
        w_res_hi = w_acc_nxt[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_res_lo = w_div_zero ? {WIDTH{1'b1}} : w_acc_nxt[WIDTH-1:0];
        w_res_hi = {WIDTH{1'b0}};
      end
      OP_MOD: begin
        w_res_lo = w_div_zero ? r_a : w_rem_nxt[WIDTH-1:0];
        w_res_hi = {WIDTH{1'b0}};
      end
      default: begin
        w_res_lo = {WIDTH{1'b0}};
        w_res_hi = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control FSM, iteration counter, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_op        <= 4'b0000;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_dest      <= {DEST_W{1'b0}};
      r_acc       <= {(2*WIDTH){1'b0}};
      r_rem       <= {(WIDTH+1){1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dz        <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_dest_out  <= {DEST_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WIDTH);
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_dest  <= dest_in;
            r_rem   <= {(WIDTH+1){1'b0}};
            // Multiplier (MUL) or dividend (DIV/MOD) starts in the low half.
            r_acc   <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_acc <= w_acc_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state     <= ST_FIN;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_dz        <= w_div_zero;
              r_result    <= w_res_lo;
              r_result_hi <= w_res_hi;
              r_dest_out  <= r_dest;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign dest_out  = r_dest_out;
  assign dz        = r_dz;

endmodule
